// File: rtl/bp_debug_ctrl.sv
// Breakpoint responder: holds the CPU on stall_breakpoint, releases it with a one-cycle continue_sig pulse.
// Latency: halt 1 edge, auto-release 2 edges, button 2+DEBOUNCE_CYCLES+1 edges; no backpressure.
module bp_debug_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_breakpoint,
    input  logic        btn_continue,
    input  logic        auto_continue,
    output logic        continue_sig,
    output logic        halted,
    output logic [15:0] hit_count,
    output logic [31:0] halt_cycles
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_s1_q, btn_s2_q;
    logic             deb_lvl_q, deb_lvl_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             press_q, press_d;

    state_e           state_q, state_d;
    logic             cont_q, cont_d;
    logic [15:0]      hit_cnt_q, hit_cnt_d;
    logic [31:0]      halt_cnt_q, halt_cnt_d;

    // Debounce: the synchronized level must differ from the accepted level for
    // DEBOUNCE_CYCLES consecutive samples before it is taken; press marks 0->1 acceptance.
    always_comb begin
        deb_lvl_d = deb_lvl_q;
        deb_cnt_d = deb_cnt_q;
        press_d   = 1'b0;
        if (btn_s2_q == deb_lvl_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_lvl_d = btn_s2_q;
            deb_cnt_d = '0;
            press_d   = btn_s2_q;
        end else begin
            deb_cnt_d = deb_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        cont_d     = 1'b0;
        hit_cnt_d  = hit_cnt_q;
        halt_cnt_d = halt_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (stall_breakpoint) begin
                    state_d    = ST_HALTED;
                    hit_cnt_d  = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
                    halt_cnt_d = 32'd1;
                end
            end
            ST_HALTED: begin
                halt_cnt_d = (halt_cnt_q == 32'hFFFF_FFFF) ? halt_cnt_q : halt_cnt_q + 32'd1;
                // A flushed breakpoint wins over a release request in the same cycle.
                if (!stall_breakpoint) begin
                    state_d = ST_RUN;
                end else if (press_q || auto_continue) begin
                    state_d = ST_RELEASE;
                    cont_d  = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!stall_breakpoint) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            deb_lvl_q  <= 1'b0;
            deb_cnt_q  <= '0;
            press_q    <= 1'b0;
            state_q    <= ST_RUN;
            cont_q     <= 1'b0;
            hit_cnt_q  <= 16'd0;
            halt_cnt_q <= 32'd0;
        end else begin
            btn_s1_q   <= btn_continue;
            btn_s2_q   <= btn_s1_q;
            deb_lvl_q  <= deb_lvl_d;
            deb_cnt_q  <= deb_cnt_d;
            press_q    <= press_d;
            state_q    <= state_d;
            cont_q     <= cont_d;
            hit_cnt_q  <= hit_cnt_d;
            halt_cnt_q <= halt_cnt_d;
        end
    end

    assign continue_sig = cont_q;
    assign halted       = (state_q != ST_RUN);
    assign hit_count    = hit_cnt_q;
    assign halt_cycles  = halt_cnt_q;

endmodule

// File: tb/tb_bp_debug_ctrl.sv
// Directed bench for bp_debug_ctrl with a short debounce window.
module tb_bp_debug_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_breakpoint;
    logic        btn_continue;
    logic        auto_continue;
    logic        continue_sig;
    logic        halted;
    logic [15:0] hit_count;
    logic [31:0] halt_cycles;

    int n_chk = 0;
    int n_err = 0;

    bp_debug_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_breakpoint (stall_breakpoint),
        .btn_continue     (btn_continue),
        .auto_continue    (auto_continue),
        .continue_sig     (continue_sig),
        .halted           (halted),
        .hit_count        (hit_count),
        .halt_cycles      (halt_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int pulses;
    int first;

    initial begin
        rst              = 1'b1;
        stall_breakpoint = 1'b1;
        btn_continue     = 1'b1;
        auto_continue    = 1'b0;

        // 1: reset dominates a high stall and button
        tick();
        check("t1_r1_halted", halted, 0);
        check("t1_r1_cont", continue_sig, 0);
        check("t1_r1_hits", hit_count, 0);
        check("t1_r1_hcyc", halt_cycles, 0);
        tick();
        check("t1_r2_halted", halted, 0);
        check("t1_r2_hits", hit_count, 0);
        rst = 1'b0;
        tick();
        check("t1_halted", halted, 1);
        check("t1_hits", hit_count, 1);
        check("t1_hcyc", halt_cycles, 1);
        btn_continue     = 1'b0;
        stall_breakpoint = 1'b0;
        tick();
        check("t1_run", halted, 0);

        // 2: debounced button release, pulse 7 edges after the rise
        do_reset();
        stall_breakpoint = 1'b1;
        tick();
        check("t2_halted", halted, 1);
        btn_continue = 1'b1;
        pulses = 0;
        first  = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (continue_sig) begin
                pulses++;
                if (first == 0) first = k;
            end
            if (first != 0 && k == first + 1) stall_breakpoint = 1'b0;
        end
        check("t2_pulses", pulses, 1);
        check("t2_edge", first, 7);
        check("t2_halted", halted, 0);
        check("t2_hits", hit_count, 1);
        check("t2_hcyc", halt_cycles, 8);
        btn_continue = 1'b0;

        // 3: glitching button never qualifies
        do_reset();
        stall_breakpoint = 1'b1;
        tick();
        pulses = 0;
        for (int k = 0; k < 14; k++) begin
            btn_continue = (k < 8) ? ((k % 2) == 0) : 1'b0;
            tick();
            if (continue_sig) pulses++;
        end
        check("t3_pulses", pulses, 0);
        check("t3_halted", halted, 1);
        check("t3_hcyc", halt_cycles, 15);
        stall_breakpoint = 1'b0;
        tick();

        // 4: auto-continue across five loop iterations
        do_reset();
        auto_continue = 1'b1;
        pulses = 0;
        for (int r = 0; r < 5; r++) begin
            stall_breakpoint = 1'b1;
            for (int k = 1; k <= 3; k++) begin
                tick();
                if (continue_sig) begin
                    pulses++;
                    check("t4_pos", k, 2);
                end
            end
            stall_breakpoint = 1'b0;
            tick();
            check("t4_run_nopulse", continue_sig, 0);
        end
        check("t4_pulses", pulses, 5);
        check("t4_hits", hit_count, 5);
        check("t4_halted", halted, 0);
        auto_continue = 1'b0;

        // 5: flush beats a coincident press; press in RUN is not remembered
        do_reset();
        stall_breakpoint = 1'b1;
        tick();
        btn_continue = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        stall_breakpoint = 1'b0;
        tick();
        check("t5_cont", continue_sig, 0);
        check("t5_halted", halted, 0);
        check("t5_hcyc", halt_cycles, 8);
        tick();
        check("t5_hcyc_hold", halt_cycles, 8);
        stall_breakpoint = 1'b1;
        tick();
        check("t5_rehit_hcyc", halt_cycles, 1);
        check("t5_rehit_hits", hit_count, 2);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (continue_sig) pulses++;
        end
        check("t5_no_stale_press", pulses, 0);
        check("t5_still_halted", halted, 1);
        btn_continue     = 1'b0;
        stall_breakpoint = 1'b0;
        tick();

        // 6: hit counter saturation, then reset mid-halt
        do_reset();
        auto_continue = 1'b1;
        force dut.hit_cnt_q = 16'hFFFE;
        #1;
        release dut.hit_cnt_q;
        #1;
        check("t6_preload", hit_count, 16'hFFFE);
        for (int r = 0; r < 2; r++) begin
            stall_breakpoint = 1'b1;
            for (int k = 0; k < 3; k++) tick();
            stall_breakpoint = 1'b0;
            tick();
        end
        check("t6_sat", hit_count, 16'hFFFF);
        stall_breakpoint = 1'b1;
        tick();
        check("t6_sat_hold", hit_count, 16'hFFFF);
        check("t6_halted", halted, 1);
        rst = 1'b1;
        tick();
        check("t6_rst_halted", halted, 0);
        check("t6_rst_cont", continue_sig, 0);
        check("t6_rst_hits", hit_count, 0);
        check("t6_rst_hcyc", halt_cycles, 0);
        rst              = 1'b0;
        stall_breakpoint = 1'b0;
        auto_continue    = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
